// File: rtl/ayatsuki_dmem_pkg.sv
// ayatsuki_dmem_pkg
// Shared definitions for the ayatsuki data-memory responder: bus types, the MMIO register
// offsets, status bit indices, and the address classifier used for both read and write ports.
// No ports (package).

package ayatsuki_dmem_pkg;

    typedef logic [31:0] data_bus_t;
    typedef logic [31:0] mem_addr_bus_t;

    localparam data_bus_t DATA_ZERO = 32'h0000_0000;

    // Offsets inside the MMIO window.
    localparam mem_addr_bus_t DMEM_CNT_LO_OFF = 32'h0;
    localparam mem_addr_bus_t DMEM_CNT_HI_OFF = 32'h4;
    localparam mem_addr_bus_t DMEM_STATUS_OFF = 32'h8;

    // Status register bit indices.
    localparam int unsigned DMEM_ST_MISALIGN_BIT = 0;
    localparam int unsigned DMEM_ST_OOR_BIT      = 1;

    // Classification of one access address.
    typedef struct packed {
        logic misaligned;  // addr[1:0] != 0
        logic oor;         // neither inside the RAM nor on an MMIO register
        logic ram;         // legal RAM word
        logic mmio;        // legal MMIO register
    } dmem_acc_t;

    function automatic dmem_acc_t dmem_classify(
        input mem_addr_bus_t addr,
        input mem_addr_bus_t ram_last,
        input mem_addr_bus_t mmio_base,
        input logic          mmio_en
    );
        dmem_acc_t c;
        logic      aligned;
        logic      in_ram;
        logic      at_mmio;
        aligned   = (addr[1:0] == 2'b00);
        in_ram    = (addr <= ram_last);
        at_mmio   = mmio_en && ((addr == mmio_base + DMEM_CNT_LO_OFF) ||
                                (addr == mmio_base + DMEM_CNT_HI_OFF) ||
                                (addr == mmio_base + DMEM_STATUS_OFF));
        c.misaligned = !aligned;
        c.oor        = !in_ram && !at_mmio;
        c.ram        = aligned && in_ram;
        c.mmio       = aligned && at_mmio;
        return c;
    endfunction

endpackage

// File: rtl/ayatsuki_dmem_mmio.sv
// ayatsuki_dmem_mmio
// MMIO block of the data memory: 64-bit free-running cycle counter, high-word shadow that is
// captured on every low-word read, sticky 2-bit access-error status and the MMIO read mux.
// Only instantiated when AYATSUKI_DMEM_MMIO_EN is defined.
// Ports:
//   i_clk, i_rst   clock, asynchronous active-high reset
//   i_rd_lo        read of the counter low word this cycle (also loads the shadow)
//   i_rd_hi        read of the shadow high word
//   i_rd_st        read of the status register
//   i_wr_st        write to the status register this cycle
//   i_clr_bits     write data bits for the status write (1 = clear)
//   i_set_bits     error bits raised by this cycle's accesses
//   o_rd_data      selected MMIO read data (zero when nothing is selected)
//   o_err          registered OR of the status bits

module ayatsuki_dmem_mmio
    import ayatsuki_dmem_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_rd_lo,
    input  logic        i_rd_hi,
    input  logic        i_rd_st,
    input  logic        i_wr_st,
    input  logic [1:0]  i_clr_bits,
    input  logic [1:0]  i_set_bits,
    output logic [31:0] o_rd_data,
    output logic        o_err
);

    logic [63:0] r_cnt;
    logic [31:0] r_shadow_hi;
    logic [1:0]  r_status;
    logic        r_err;
    logic [1:0]  w_status_d;

    // Clear first, then set, so a same-cycle set wins.
    always_comb begin
        w_status_d = r_status;
        if (i_wr_st) begin
            w_status_d = w_status_d & ~i_clr_bits;
        end
        w_status_d = w_status_d | i_set_bits;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt       <= 64'd0;
            r_shadow_hi <= 32'd0;
            r_status    <= 2'b00;
            r_err       <= 1'b0;
        end else begin
            r_cnt    <= r_cnt + 64'd1;
            r_status <= w_status_d;
            r_err    <= |w_status_d;
            // Capture the high half alongside the low read so the pair is coherent.
            if (i_rd_lo) begin
                r_shadow_hi <= r_cnt[63:32];
            end
        end
    end

    always_comb begin
        o_rd_data = DATA_ZERO;
        if (i_rd_lo) begin
            o_rd_data = r_cnt[31:0];
        end else if (i_rd_hi) begin
            o_rd_data = r_shadow_hi;
        end else if (i_rd_st) begin
            o_rd_data = {30'd0, r_status};
        end
    end

    assign o_err = r_err;

endmodule

// File: rtl/ayatsuki_dmem.sv
// ayatsuki_dmem
// Data-memory responder for the ayatsuki_core load/store port. Big-endian 32-bit word reads are
// served combinationally; writes go through a single-entry posted buffer with store-to-load
// forwarding and reach the byte array one cycle later. Illegal (misaligned / out-of-range)
// accesses are suppressed.
// Optional: define AYATSUKI_DMEM_MMIO_EN to add the MMIO window (cycle counter, shadow, sticky
// error status); without it MMIO addresses are out of range and err_o is tied low.
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   mem_enable_i      global access qualifier
//   mem_r_enable_i    read request,  mem_r_addr_i read byte address
//   mem_w_enable_i    write request, mem_w_addr_i write byte address, mem_data_i write data
//   mem_data_o        combinational read data (zero for illegal or no request)
//   err_o             high while any status bit is set

module ayatsuki_dmem
    import ayatsuki_dmem_pkg::*;
#(
    parameter int unsigned DEPTH_BYTES = 2048,
    parameter logic [31:0] MMIO_BASE   = 32'h0000_1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_enable_i,
    input  logic        mem_r_enable_i,
    input  logic        mem_w_enable_i,
    input  logic [31:0] mem_r_addr_i,
    input  logic [31:0] mem_w_addr_i,
    input  logic [31:0] mem_data_i,
    output logic [31:0] mem_data_o,
    output logic        err_o
);

    localparam int unsigned   AW       = $clog2(DEPTH_BYTES);
    localparam mem_addr_bus_t RAM_LAST = mem_addr_bus_t'(DEPTH_BYTES - 4);
`ifdef AYATSUKI_DMEM_MMIO_EN
    localparam logic MMIO_EN = 1'b1;
`else
    localparam logic MMIO_EN = 1'b0;
`endif

    logic          w_rd_req;
    logic          w_wr_req;
    dmem_acc_t     w_rd_acc;
    dmem_acc_t     w_wr_acc;
    logic [1:0]    w_err_set;
    logic [AW-1:0] w_rd_idx;
    logic [AW-1:0] w_buf_idx;
    data_bus_t     w_ram_word;
    data_bus_t     w_mmio_rdata;

    logic [7:0]    r_ram [DEPTH_BYTES];
    logic          r_buf_valid;
    mem_addr_bus_t r_buf_addr;
    data_bus_t     r_buf_data;

    assign w_rd_req = mem_enable_i & mem_r_enable_i;
    assign w_wr_req = mem_enable_i & mem_w_enable_i;
    assign w_rd_acc = dmem_classify(mem_r_addr_i, RAM_LAST, MMIO_BASE, MMIO_EN);
    assign w_wr_acc = dmem_classify(mem_w_addr_i, RAM_LAST, MMIO_BASE, MMIO_EN);

    always_comb begin
        w_err_set = 2'b00;
        w_err_set[DMEM_ST_MISALIGN_BIT] = (w_rd_req & w_rd_acc.misaligned) |
                                          (w_wr_req & w_wr_acc.misaligned);
        w_err_set[DMEM_ST_OOR_BIT]      = (w_rd_req & w_rd_acc.oor) |
                                          (w_wr_req & w_wr_acc.oor);
    end

    // Legal RAM addresses are word aligned, so OR-ing in the byte lane never carries.
    assign w_rd_idx   = mem_r_addr_i[AW-1:0];
    assign w_buf_idx  = r_buf_addr[AW-1:0];
    assign w_ram_word = {r_ram[w_rd_idx],           r_ram[w_rd_idx | AW'(1)],
                         r_ram[w_rd_idx | AW'(2)],  r_ram[w_rd_idx | AW'(3)]};

    // Posted write buffer: every valid entry drains on the next edge, so it never overflows.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_buf_valid <= 1'b0;
            r_buf_addr  <= '0;
            r_buf_data  <= DATA_ZERO;
        end else begin
            r_buf_valid <= w_wr_req & w_wr_acc.ram;
            if (w_wr_req & w_wr_acc.ram) begin
                r_buf_addr <= mem_w_addr_i;
                r_buf_data <= mem_data_i;
            end
        end
    end

    // Array is not reset.
    always_ff @(posedge clk) begin
        if (r_buf_valid) begin
            r_ram[w_buf_idx]          <= r_buf_data[31:24];
            r_ram[w_buf_idx | AW'(1)] <= r_buf_data[23:16];
            r_ram[w_buf_idx | AW'(2)] <= r_buf_data[15:8];
            r_ram[w_buf_idx | AW'(3)] <= r_buf_data[7:0];
        end
    end

    always_comb begin
        mem_data_o = DATA_ZERO;
        if (w_rd_req) begin
            if (w_rd_acc.ram) begin
                if (r_buf_valid && (r_buf_addr == mem_r_addr_i)) begin
                    mem_data_o = r_buf_data;
                end else begin
                    mem_data_o = w_ram_word;
                end
            end else if (w_rd_acc.mmio) begin
                mem_data_o = w_mmio_rdata;
            end
        end
    end

`ifdef AYATSUKI_DMEM_MMIO_EN
    logic w_rd_mmio;
    logic w_wr_st;
    assign w_rd_mmio = w_rd_req & w_rd_acc.mmio;
    assign w_wr_st   = w_wr_req & w_wr_acc.mmio & (mem_w_addr_i == MMIO_BASE + DMEM_STATUS_OFF);

    ayatsuki_dmem_mmio u_mmio (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_rd_lo    (w_rd_mmio & (mem_r_addr_i == MMIO_BASE + DMEM_CNT_LO_OFF)),
        .i_rd_hi    (w_rd_mmio & (mem_r_addr_i == MMIO_BASE + DMEM_CNT_HI_OFF)),
        .i_rd_st    (w_rd_mmio & (mem_r_addr_i == MMIO_BASE + DMEM_STATUS_OFF)),
        .i_wr_st    (w_wr_st),
        .i_clr_bits (mem_data_i[1:0]),
        .i_set_bits (w_err_set),
        .o_rd_data  (w_mmio_rdata),
        .o_err      (err_o)
    );
`else
    logic w_unused_mmio;
    assign w_unused_mmio = ^{w_wr_acc.mmio, w_err_set};
    assign w_mmio_rdata  = DATA_ZERO;
    assign err_o         = 1'b0;
`endif

endmodule

// File: tb/tb_ayatsuki_dmem.sv
module tb_ayatsuki_dmem;

    localparam int unsigned DEPTH = 2048;
    localparam logic [31:0] BASE  = 32'h0000_1000;
`ifdef AYATSUKI_DMEM_MMIO_EN
    localparam bit MMIO_EN = 1'b1;
`else
    localparam bit MMIO_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_enable_i, mem_r_enable_i, mem_w_enable_i;
    logic [31:0] mem_r_addr_i, mem_w_addr_i, mem_data_i;
    logic [31:0] mem_data_o;
    logic        err_o;

    int n_checks = 0;
    int n_errors = 0;

    ayatsuki_dmem #(.DEPTH_BYTES(DEPTH), .MMIO_BASE(BASE)) dut (
        .clk            (clk),
        .rst            (rst),
        .mem_enable_i   (mem_enable_i),
        .mem_r_enable_i (mem_r_enable_i),
        .mem_w_enable_i (mem_w_enable_i),
        .mem_r_addr_i   (mem_r_addr_i),
        .mem_w_addr_i   (mem_w_addr_i),
        .mem_data_i     (mem_data_i),
        .mem_data_o     (mem_data_o),
        .err_o          (err_o)
    );

    always #5 clk = ~clk;

    // Reference model: a word map of completed writes, the write still in flight (lost on
    // reset), the status bits, the counter and its shadow.
    logic [31:0]     mdl_mem [int unsigned];
    bit              pend_v;
    logic [31:0]     pend_a, pend_d;
    logic [1:0]      mdl_status;
    longint unsigned mdl_cnt;
    logic [31:0]     mdl_shadow;

    function automatic bit m_ram_ok(input logic [31:0] a);
        return (a % 4 == 0) && (a <= DEPTH - 4);
    endfunction

    function automatic bit m_mmio(input logic [31:0] a);
        return MMIO_EN && (a == BASE || a == BASE + 4 || a == BASE + 8);
    endfunction

    function automatic bit m_known(input bit rd, input logic [31:0] a);
        if (rd && m_ram_ok(a)) return (pend_v && pend_a == a) || mdl_mem.exists(a);
        return 1'b1;
    endfunction

    function automatic logic [31:0] m_read(input bit rd, input logic [31:0] a);
        if (!rd) return 32'h0;
        if (m_ram_ok(a)) begin
            if (pend_v && pend_a == a) return pend_d;
            return mdl_mem[a];
        end
        if (m_mmio(a)) begin
            if (a == BASE)     return mdl_cnt[31:0];
            if (a == BASE + 4) return mdl_shadow;
            return {30'd0, mdl_status};
        end
        return 32'h0;
    endfunction

    function automatic void m_reset();
        pend_v     = 1'b0;
        mdl_status = 2'b00;
        mdl_cnt    = 0;
        mdl_shadow = 32'h0;
    endfunction

    function automatic void m_edge();
        bit         rd, wr;
        logic [1:0] set, clr;
        if (rst) return;
        rd  = mem_enable_i && mem_r_enable_i;
        wr  = mem_enable_i && mem_w_enable_i;
        set = 2'b00;
        clr = 2'b00;
        if (rd && (mem_r_addr_i % 4 != 0)) set[0] = 1'b1;
        if (wr && (mem_w_addr_i % 4 != 0)) set[0] = 1'b1;
        if (rd && !(mem_r_addr_i <= DEPTH - 4) && !m_mmio(mem_r_addr_i)) set[1] = 1'b1;
        if (wr && !(mem_w_addr_i <= DEPTH - 4) && !m_mmio(mem_w_addr_i)) set[1] = 1'b1;
        if (wr && m_mmio(mem_w_addr_i) && mem_w_addr_i == BASE + 8) clr = mem_data_i[1:0];
        if (MMIO_EN) begin
            mdl_status = (mdl_status & ~clr) | set;
            if (rd && mem_r_addr_i == BASE) mdl_shadow = mdl_cnt[63:32];
        end
        mdl_cnt = mdl_cnt + 1;
        if (pend_v) mdl_mem[pend_a] = pend_d;
        pend_v = wr && m_ram_ok(mem_w_addr_i);
        pend_a = mem_w_addr_i;
        pend_d = mem_data_i;
    endfunction

    task automatic tick();
        @(posedge clk);
        m_edge();
        @(negedge clk);
    endtask

    task automatic drive(input logic en, input logic ren, input logic [31:0] ra,
                         input logic wen, input logic [31:0] wa, input logic [31:0] wd);
        mem_enable_i   = en;
        mem_r_enable_i = ren;
        mem_r_addr_i   = ra;
        mem_w_enable_i = wen;
        mem_w_addr_i   = wa;
        mem_data_i     = wd;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        m_reset();
        drive(0, 0, 0, 0, 0, 0);
        repeat (2) @(negedge clk);
        #1;
        n_checks++;
        if (err_o !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_err: got %b expected 0", err_o);
        end
        drive(1, 1, BASE + 8, 0, 0, 0);
        n_checks++;
        if (mem_data_o !== 32'h0) begin
            n_errors++;
            $display("FAIL reset_status: got %h expected 0", mem_data_o);
        end
        drive(1, 1, BASE, 0, 0, 0);
        n_checks++;
        if (mem_data_o !== 32'h0) begin
            n_errors++;
            $display("FAIL reset_cnt: got %h expected 0", mem_data_o);
        end
        drive(0, 0, 0, 0, 0, 0);
        rst = 1'b0;
    endtask

    task automatic test_counter();
        logic [31:0] exp;
        repeat (10) tick();
        drive(1, 1, BASE, 0, 0, 0);
        exp = MMIO_EN ? 32'd10 : 32'd0;
        n_checks++;
        if (mem_data_o !== exp) begin
            n_errors++;
            $display("FAIL cnt_after_10: got %h expected %h", mem_data_o, exp);
        end
        tick();
        drive(1, 1, BASE + 4, 0, 0, 0);
        exp = m_read(1, BASE + 4);
        n_checks++;
        if (mem_data_o !== exp) begin
            n_errors++;
            $display("FAIL cnt_shadow_hi: got %h expected %h", mem_data_o, exp);
        end
        tick();
    endtask

    task automatic test_store_load();
        logic [7:0] exp_b [4];
        exp_b = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
        drive(1, 0, 0, 1, 32'h10, 32'hDEADBEEF);
        tick();
        drive(1, 1, 32'h10, 0, 0, 0);
        n_checks++;
        if (mem_data_o !== 32'hDEADBEEF) begin
            n_errors++;
            $display("FAIL fwd_load: got %h expected deadbeef", mem_data_o);
        end
        tick();
        drive(0, 0, 0, 0, 0, 0);
        tick();
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (dut.r_ram[16 + i] !== exp_b[i]) begin
                n_errors++;
                $display("FAIL byte_order[%0d]: got %h expected %h", i, dut.r_ram[16 + i],
                         exp_b[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        drive(1, 0, 0, 1, 32'h20, 32'd1);
        tick();
        drive(1, 0, 0, 1, 32'h24, 32'd2);
        tick();
        drive(1, 1, 32'h20, 1, 32'h20, 32'd3);
        n_checks++;
        if (mem_data_o !== 32'd1) begin
            n_errors++;
            $display("FAIL b2b_same_cycle_old: got %h expected 1", mem_data_o);
        end
        tick();
        drive(1, 1, 32'h20, 0, 0, 0);
        n_checks++;
        if (mem_data_o !== 32'd3) begin
            n_errors++;
            $display("FAIL b2b_last_wins_fwd: got %h expected 3", mem_data_o);
        end
        tick();
        repeat (2) tick();
        drive(1, 1, 32'h20, 0, 0, 0);
        n_checks++;
        if (mem_data_o !== 32'd3) begin
            n_errors++;
            $display("FAIL b2b_0x20: got %h expected 3", mem_data_o);
        end
        drive(1, 1, 32'h24, 0, 0, 0);
        n_checks++;
        if (mem_data_o !== 32'd2) begin
            n_errors++;
            $display("FAIL b2b_0x24: got %h expected 2", mem_data_o);
        end
        tick();
    endtask

    task automatic test_misaligned();
        logic [31:0] exp;
        drive(1, 0, 0, 1, 32'h12, 32'd5);
        tick();
        drive(1, 1, BASE + 8, 0, 0, 0);
        n_checks++;
        if (err_o !== MMIO_EN) begin
            n_errors++;
            $display("FAIL mis_err: got %b expected %b", err_o, MMIO_EN);
        end
        exp = MMIO_EN ? 32'd1 : 32'd0;
        n_checks++;
        if (mem_data_o !== exp) begin
            n_errors++;
            $display("FAIL mis_status: got %h expected %h", mem_data_o, exp);
        end
        tick();
        drive(1, 1, 32'h10, 1, BASE + 8, 32'd1);
        n_checks++;
        if (mem_data_o !== 32'hDEADBEEF) begin
            n_errors++;
            $display("FAIL mis_array_kept: got %h expected deadbeef", mem_data_o);
        end
        tick();
        drive(1, 1, BASE + 8, 0, 0, 0);
        n_checks++;
        if (err_o !== 1'b0 || mem_data_o !== 32'h0) begin
            n_errors++;
            $display("FAIL mis_clear: got err=%b st=%h expected err=0 st=0", err_o, mem_data_o);
        end
        tick();
    endtask

    task automatic test_out_of_range();
        logic [31:0] exp;
        drive(1, 1, DEPTH, 0, 0, 0);
        n_checks++;
        if (mem_data_o !== 32'h0) begin
            n_errors++;
            $display("FAIL oor_data: got %h expected 0", mem_data_o);
        end
        tick();
        // Clear bit1 while a new out-of-range read sets it: set wins.
        drive(1, 1, DEPTH, 1, BASE + 8, 32'd2);
        tick();
        drive(1, 1, BASE + 8, 0, 0, 0);
        exp = MMIO_EN ? 32'd2 : 32'd0;
        n_checks++;
        if (mem_data_o !== exp) begin
            n_errors++;
            $display("FAIL oor_set_wins: got %h expected %h", mem_data_o, exp);
        end
        tick();
        // Misaligned and out of range at once raises both bits.
        drive(1, 1, DEPTH - 1, 0, 0, 0);
        tick();
        drive(1, 1, BASE + 8, 0, 0, 0);
        exp = MMIO_EN ? 32'd3 : 32'd0;
        n_checks++;
        if (mem_data_o !== exp) begin
            n_errors++;
            $display("FAIL oor_both_bits: got %h expected %h", mem_data_o, exp);
        end
        tick();
        drive(1, 0, 0, 1, BASE + 8, 32'd3);
        tick();
        drive(0, 0, 0, 0, 0, 0);
        n_checks++;
        if (err_o !== 1'b0) begin
            n_errors++;
            $display("FAIL oor_clear_err: got %b expected 0", err_o);
        end
    endtask

    task automatic test_reset_mid_write();
        drive(1, 0, 0, 1, 32'h30, 32'h11223344);
        tick();
        drive(0, 0, 0, 0, 0, 0);
        repeat (2) tick();
        drive(1, 0, 0, 1, 32'h30, 32'd7);
        tick();
        rst = 1'b1;
        m_reset();
        drive(0, 0, 0, 0, 0, 0);
        repeat (2) tick();
        rst = 1'b0;
        drive(1, 1, 32'h30, 0, 0, 0);
        n_checks++;
        if (mem_data_o !== 32'h11223344 || dut.r_ram[48] !== 8'h11) begin
            n_errors++;
            $display("FAIL rst_mid_write: got %h/%h expected 11223344/11", mem_data_o,
                     dut.r_ram[48]);
        end
        drive(1, 1, BASE, 0, 0, 0);
        n_checks++;
        if (mem_data_o !== 32'h0) begin
            n_errors++;
            $display("FAIL rst_cnt: got %h expected 0", mem_data_o);
        end
        drive(1, 1, BASE + 8, 0, 0, 0);
        n_checks++;
        if (mem_data_o !== 32'h0 || err_o !== 1'b0) begin
            n_errors++;
            $display("FAIL rst_status: got %h err=%b expected 0", mem_data_o, err_o);
        end
        tick();
    endtask

    function automatic logic [31:0] rand_addr();
        case ($urandom_range(0, 9))
            0, 1, 2, 3, 4, 5: return 32'h40 + 4 * $urandom_range(0, 15);
            6:                return 32'h40 + $urandom_range(0, 63);
            7:                return DEPTH - 4 + 2 * $urandom_range(0, 5);
            8:                return BASE + 4 * $urandom_range(0, 2);
            default:          return BASE + 12 - $urandom_range(0, 1);
        endcase
    endfunction

    task automatic test_random();
        logic        en, ren, wen;
        logic [31:0] ra, wa, wd, exp;
        for (int i = 0; i < 400; i++) begin
            en  = ($urandom_range(0, 7) != 0);
            ren = $urandom_range(0, 1);
            wen = $urandom_range(0, 1);
            ra  = rand_addr();
            wa  = rand_addr();
            wd  = $urandom();
            drive(en, ren, ra, wen, wa, wd);
            n_checks++;
            if (err_o !== (mdl_status != 2'b00)) begin
                n_errors++;
                $display("FAIL rand_err[%0d]: got %b expected %b", i, err_o, mdl_status != 0);
            end
            if (m_known(en && ren, ra)) begin
                exp = m_read(en && ren, ra);
                n_checks++;
                if (mem_data_o !== exp) begin
                    n_errors++;
                    $display("FAIL rand_rd[%0d] addr %h: got %h expected %h", i, ra,
                             mem_data_o, exp);
                end
            end
            tick();
        end
    endtask

    initial begin
        rst = 1'b1;
        m_reset();
        drive(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        test_reset();
        test_counter();
        test_store_load();
        test_back_to_back();
        test_misaligned();
        test_out_of_range();
        test_reset_mid_write();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
